// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: key map, sweep classification and press FSM states.
package keypad_pkg;

    typedef enum logic [1:0] {
        SW_NONE   = 2'd0,
        SW_SINGLE = 2'd1,
        SW_MULTI  = 2'd2
    } sweep_kind_e;

    // code is kept at zero for NONE/MULTI so whole-struct compares act on the class alone
    typedef struct packed {
        sweep_kind_e kind;
        logic [3:0]  code;
    } sweep_t;

    typedef enum logic {
        ST_RELEASED = 1'b0,
        ST_PRESSED  = 1'b1
    } press_state_e;

    // Entry {row, col} -> hex code; index 0 is the top-left key.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[{row, col}];
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Debounces finalized sweep results and runs the RELEASED/PRESSED press FSM.
// press_vld is combinational in the finalize cycle; the top registers it into KeyValid.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fin_vld,
    input  sweep_t     fin_dat,
    output logic       press_vld,
    output logic [3:0] press_code,
    output logic       key_held
);

    localparam int MW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [MW-1:0] MATCH_MAX = MW'(DEBOUNCE_SCANS);

    sweep_t        last_q, last_d;
    logic [MW-1:0] match_q, match_d;
    press_state_e  state_q, state_d;
    logic          stable_evt;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q  <= '{kind: SW_NONE, code: 4'h0};
            match_q <= '0;
            state_q <= ST_RELEASED;
        end else begin
            last_q  <= last_d;
            match_q <= match_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        last_d     = last_q;
        match_d    = match_q;
        state_d    = state_q;
        stable_evt = 1'b0;
        press_vld  = 1'b0;

        // Only the sweep that makes the count reach the threshold fires an event.
        if (fin_vld) begin
            if (fin_dat == last_q) begin
                if (match_q != MATCH_MAX) begin
                    match_d    = match_q + MW'(1);
                    stable_evt = (match_d == MATCH_MAX);
                end
            end else begin
                last_d     = fin_dat;
                match_d    = MW'(1);
                stable_evt = (MATCH_MAX == MW'(1));
            end
        end

        if (stable_evt) begin
            case (state_q)
                ST_RELEASED: begin
                    if (last_d.kind == SW_SINGLE) begin
                        state_d   = ST_PRESSED;
                        press_vld = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (last_d.kind == SW_NONE) begin
                        state_d = ST_RELEASED;
                    end
                end
                default: state_d = ST_RELEASED;
            endcase
        end
    end

    assign press_code = last_d.code;
    assign key_held   = (state_q == ST_PRESSED);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner: synchronizes rows, classifies each sweep, debounces presses.
// KeyValid pulses the cycle after the column-3 sample of the sweep that makes a key stable.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES    = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [3:0]  Row,
    input  logic        Clear,
    output logic [3:0]  Col,
    output logic [3:0]  KeyCode,
    output logic        KeyValid,
    output logic        KeyHeld,
    output logic [15:0] Value
);

    localparam int CW = $clog2(SCAN_CYCLES);

    logic [3:0]    row_meta_q, row_sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    col_q, col_d;
    sweep_t        acc_q, acc_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic [15:0]   value_q, value_d;

    logic          sample;
    logic          fin_vld;
    sweep_t        col_base, merged;
    logic [3:0]    row_low;
    logic [2:0]    low_cnt;
    logic [1:0]    low_row;
    logic          press_vld;
    logic [3:0]    press_code;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            row_meta_q  <= '0;
            row_sync_q  <= '0;
            cnt_q       <= '0;
            col_q       <= '0;
            acc_q       <= '{kind: SW_NONE, code: 4'h0};
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            value_q     <= '0;
        end else begin
            row_meta_q  <= Row;
            row_sync_q  <= row_meta_q;
            cnt_q       <= cnt_d;
            col_q       <= col_d;
            acc_q       <= acc_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            value_q     <= value_d;
        end
    end

    always_comb begin
        sample = (cnt_q == CW'(SCAN_CYCLES - 1));
        cnt_d  = sample ? '0 : cnt_q + CW'(1);
        col_d  = sample ? col_q + 2'd1 : col_q;

        row_low = ~row_sync_q;
        low_cnt = 3'd0;
        low_row = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (row_low[r]) begin
                low_cnt = low_cnt + 3'd1;
                low_row = 2'(r);
            end
        end

        // Column 0 starts a fresh sweep; later columns fold into the running result.
        col_base = (col_q == 2'd0) ? '{kind: SW_NONE, code: 4'h0} : acc_q;
        case (low_cnt)
            3'd0:    merged = col_base;
            3'd1:    merged = (col_base.kind == SW_NONE)
                            ? '{kind: SW_SINGLE, code: key_code(low_row, col_q)}
                            : '{kind: SW_MULTI,  code: 4'h0};
            default: merged = '{kind: SW_MULTI, code: 4'h0};
        endcase

        acc_d   = sample ? merged : acc_q;
        fin_vld = sample && (col_q == 2'd3);
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk        (Clk),
        .reset      (Reset),
        .fin_vld    (fin_vld),
        .fin_dat    (merged),
        .press_vld  (press_vld),
        .press_code (press_code),
        .key_held   (KeyHeld)
    );

    always_comb begin
        key_valid_d = press_vld;
        key_code_d  = press_vld ? press_code : key_code_q;
        if (Clear) begin
            value_d = '0;
        end else if (press_vld) begin
            value_d = {value_q[11:0], press_code};
        end else begin
            value_d = value_q;
        end
    end

    assign Col      = ~(4'b0001 << col_q);
    assign KeyCode  = key_code_q;
    assign KeyValid = key_valid_q;
    assign Value    = value_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a combinational 4x4 keypad model (8-clock columns, 32-clock sweeps).
module tb_keypad_scanner;

    logic        Clk;
    logic        Reset;
    logic [3:0]  Row;
    logic        Clear;
    logic [3:0]  Col;
    logic [3:0]  KeyCode;
    logic        KeyValid;
    logic        KeyHeld;
    logic [15:0] Value;

    logic [15:0] pressed;
    int          checks;
    int          errors;
    int          pulses;

    keypad_scanner #(
        .SCAN_CYCLES    (8),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Row      (Row),
        .Clear    (Clear),
        .Col      (Col),
        .KeyCode  (KeyCode),
        .KeyValid (KeyValid),
        .KeyHeld  (KeyHeld),
        .Value    (Value)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Key (r,c) pulls Row[r] low while Col[c] is driven low.
    always_comb begin
        Row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && (Col[c] == 1'b0)) Row[r] = 1'b0;
            end
        end
    end

    always @(negedge Clk) begin
        if (!Reset && KeyValid === 1'b1) pulses++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    localparam int KEY_IDX  [5] = '{0, 1, 2, 3, 15};
    localparam int KEY_CODE [5] = '{1, 2, 3, 10, 13};

    initial begin
        checks  = 0;
        errors  = 0;
        pulses  = 0;
        pressed = '0;
        Clear   = 1'b0;
        Reset   = 1'b1;

        // 1: reset state and idle column rotation
        tick(3);
        Reset = 1'b0;
        check_eq("rst_col", Col, 4'b1110);
        check_eq("rst_valid", KeyValid, 1'b0);
        check_eq("rst_held", KeyHeld, 1'b0);
        check_eq("rst_code", KeyCode, 4'h0);
        check_eq("rst_value", Value, 16'h0);
        tick(7);
        check_eq("col0_last", Col, 4'b1110);
        tick(1);
        check_eq("col1", Col, 4'b1101);
        tick(8);
        check_eq("col2", Col, 4'b1011);
        tick(8);
        check_eq("col3", Col, 4'b0111);
        tick(8);
        check_eq("col_wrap", Col, 4'b1110);
        check_eq("idle_pulses", pulses, 0);
        check_eq("idle_value", Value, 16'h0);

        // 2: hold '5' for six sweeps, then release
        pressed = 16'h1 << 5;
        tick(95);
        check_eq("k5_before", KeyValid, 1'b0);
        tick(1);
        check_eq("k5_valid", KeyValid, 1'b1);
        check_eq("k5_code", KeyCode, 4'h5);
        check_eq("k5_value", Value, 16'h0005);
        check_eq("k5_held", KeyHeld, 1'b1);
        tick(1);
        check_eq("k5_pulse_end", KeyValid, 1'b0);
        tick(95);
        pressed = '0;
        check_eq("k5_pulses", pulses, 1);
        tick(95);
        check_eq("k5_held_late", KeyHeld, 1'b1);
        tick(1);
        check_eq("k5_released", KeyHeld, 1'b0);

        // 3: keys 1, 2, 3, A, D
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            pressed = 16'h1 << KEY_IDX[i];
            tick(128);
            check_eq("seq_code", KeyCode, KEY_CODE[i]);
            check_eq("seq_held", KeyHeld, 1'b1);
            pressed = '0;
            tick(128);
            check_eq("seq_rel", KeyHeld, 1'b0);
            if (i == 3) check_eq("seq_value4", Value, 16'h123A);
        end
        check_eq("seq_value5", Value, 16'h23AD);
        check_eq("seq_pulses", pulses, 5);

        // 4: '7' bouncing on alternate sweeps never stabilizes
        pulses = 0;
        for (int s = 0; s < 8; s++) begin
            pressed = (s % 2 == 0) ? (16'h1 << 8) : 16'h0;
            tick(32);
        end
        pressed = '0;
        tick(96);
        check_eq("bounce_pulses", pulses, 0);
        check_eq("bounce_value", Value, 16'h23AD);
        check_eq("bounce_held", KeyHeld, 1'b0);

        // 5: '1'+'2' together is ignored; '1' alone then reports
        pulses = 0;
        pressed = 16'h0003;
        tick(192);
        check_eq("multi_pulses", pulses, 0);
        check_eq("multi_held", KeyHeld, 1'b0);
        pressed = 16'h0001;
        tick(95);
        check_eq("single_before", KeyValid, 1'b0);
        tick(1);
        check_eq("single_valid", KeyValid, 1'b1);
        check_eq("single_code", KeyCode, 4'h1);
        check_eq("single_value", Value, 16'h3AD1);
        pressed = '0;
        tick(128);
        check_eq("single_pulses", pulses, 1);

        // 6: Clear against the 'C' shift, then reset while 'C' is held
        pulses = 0;
        pressed = 16'h1 << 11;
        tick(95);
        Clear = 1'b1;
        tick(1);
        check_eq("clr_valid", KeyValid, 1'b1);
        check_eq("clr_code", KeyCode, 4'hC);
        check_eq("clr_value", Value, 16'h0);
        tick(1);
        Clear = 1'b0;
        check_eq("clr_value_hold", Value, 16'h0);
        check_eq("clr_held", KeyHeld, 1'b1);
        tick(31);
        Reset = 1'b1;
        tick(2);
        Reset = 1'b0;
        check_eq("mid_rst_code", KeyCode, 4'h0);
        check_eq("mid_rst_valid", KeyValid, 1'b0);
        check_eq("mid_rst_held", KeyHeld, 1'b0);
        check_eq("mid_rst_value", Value, 16'h0);
        check_eq("mid_rst_col", Col, 4'b1110);
        tick(95);
        check_eq("rerep_before", KeyValid, 1'b0);
        tick(1);
        check_eq("rerep_valid", KeyValid, 1'b1);
        check_eq("rerep_code", KeyCode, 4'hC);
        check_eq("rerep_value", Value, 16'h000C);
        pressed = '0;
        tick(128);
        check_eq("rerep_pulses", pulses, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Input-side counterpart of the board's multiplexed seven-segment driver. It scans a 4x4 hex keypad (Pmod KYPD style) one column at a time and reads the rows back. Each key press is debounced and reported as a 4-bit hex code with a one-cycle valid pulse. Codes are also shifted into a 16-bit entry register that can feed the display's 16-bit data input directly.

Parameters:
SCAN_CYCLES, 100000, clocks each column is driven (1 ms at 100 MHz); must be >= 4
DEBOUNCE_SCANS, 4, consecutive identical full sweeps required before a result is accepted; must be >= 1

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous, active-high reset
Row  input  4  keypad rows, active-low (pulled up), asynchronous; Row[0] = top row
Clear  input  1  synchronous clear of Value
Col  output  4  column drive, active-low, exactly one bit low; Col[0] = leftmost column
KeyCode  output  4  code of the last accepted key
KeyValid  output  1  one-cycle pulse on each accepted press
KeyHeld  output  1  high while the accepted key remains pressed
Value  output  16  entry register; each new code is shifted in at [3:0]

Behaviour:
- Single clock domain (Clk). Reset is synchronous and active-high; it overrides everything.
- Reset values: Col=4'b1110, KeyCode=0, KeyValid=0, KeyHeld=0, Value=0; all counters, synchronizer flops and debounce state = 0/NONE.
- Row passes through a 2-FF synchronizer before any use.
- Column scan:
  - A cycle counter runs 0..SCAN_CYCLES-1 per column.
  - The synchronized Row is sampled when the counter equals SCAN_CYCLES-1.
  - On the next cycle the counter wraps and Col rotates: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
- Key map, indexed [row][col]:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Sweep result is built over the four column samples and finalized at the column-3 sample. It is one of:
  - NONE: zero rows low.
  - SINGLE(code): exactly one row low in exactly one column.
  - MULTI: anything else.
- Debounce:
  - If the sweep result equals the stored LastSweep, MatchCount increments, saturating at DEBOUNCE_SCANS.
  - Otherwise LastSweep <= result and MatchCount <= 1.
  - When MatchCount reaches DEBOUNCE_SCANS, LastSweep is the stable result.
- Press FSM:
  - RELEASED + stable SINGLE(k): go to PRESSED. KeyCode <= k, KeyHeld <= 1, Value <= {Value[11:0], k}. KeyValid is high for exactly the one cycle after the sweep-finalizing sample.
  - PRESSED + stable NONE: go to RELEASED, KeyHeld <= 0.
  - PRESSED + stable SINGLE(other) or MULTI: stay in PRESSED, no pulse. No auto-repeat; the key must be released first.
  - RELEASED + stable MULTI: stay in RELEASED, ignored.
- A stable result fires its transition only once. Re-evaluation needs a change in LastSweep.
- Clear forces Value=0 and takes priority over a simultaneous shift. KeyValid and KeyCode still update that cycle.
- Reset mid-press returns to RELEASED. A still-held key is re-reported after DEBOUNCE_SCANS complete sweeps, counted from the first full sweep after reset.

Decomposition:
- keypad_pkg:
  - KEY_MAP constant (16 entries, [row][col] -> code)
  - sweep class encoding NONE/SINGLE/MULTI
  - FSM state encoding RELEASED/PRESSED
- One sub-module, keypad_debounce: takes the sweep result plus a finalize strobe; outputs the press/release events and the stable code.
- Scanner counter, synchronizer and Value register stay in the top-level module.

Test Plan:
Bench uses SCAN_CYCLES=8, DEBOUNCE_SCANS=3 (sweep = 32 clocks). The keypad model pulls Row[r] low while Col[c] is low and key (r,c) is pressed.
1. Reset, then idle -> Col=1110 for 8 clocks, then 1101, 1011, 0111, 1110; KeyValid/KeyHeld/Value stay 0.
2. Hold '5' (r1,c1) for 6 sweeps, then release -> exactly one KeyValid pulse, KeyCode=5, Value=16'h0005, KeyHeld=1; KeyHeld drops to 0 three sweeps after release.
3. Press/release 1, 2, 3, A, then D -> five pulses; Value=16'h123A after four keys, 16'h23AD after the fifth.
4. Toggle '7' pressed/released on alternate sweeps for 8 sweeps -> no KeyValid, Value unchanged.
5. Hold '1' and '2' together for 6 sweeps -> no KeyValid; releasing '2' leaves '1' alone for 3 sweeps -> KeyValid, KeyCode=1.
6. Assert Clear in the KeyValid cycle of 'C' -> Value=0, KeyCode=C. Assert Reset while 'C' is held -> all outputs 0, then KeyValid/KeyCode=C again after 3 sweeps.
